phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Multi-cycle control sequencer for the five-phase processor core (F, R, X, M, W).
- Drives the one-hot phase bus consumed by the program counter, register file, ALU and memory stage.
- Issues instruction- and data-memory requests and waits on acknowledges.
- Handles halt and run, can skip M for non-memory instructions, and flags memory-wait timeouts.

Parameters:
- WAIT_TIMEOUT, 255: max cycles F/M may wait for ack; 0 disables timeout.
- SKIP_MEM, 1: 1 = X goes directly to W when mem_op=0; 0 = M always visited.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- run  in  1  level; start/resume execution.
- halt_req  in  1  pulse or level; request stop at next instruction boundary.
- mem_op  in  1  decoded "instruction uses data memory"; valid during X.
- imem_ack  in  1  instruction fetch complete.
- dmem_ack  in  1  data access complete.
- phase  out  5  one-hot phase, bit0=F, 1=R, 2=X, 3=M, 4=W.
- imem_req  out  1  high throughout F.
- dmem_req  out  1  high throughout M.
- retire  out  1  one-cycle pulse, equal to phase[4].
- halted  out  1  high in HALT.
- timeout_err  out  1  sticky; set on memory-wait timeout.

Behaviour:
- All outputs are registered-state decodes. No combinational path from any input to any output.
- Reset (async, rst=1):
  - state=IDLE; phase=0; imem_req=dmem_req=retire=halted=timeout_err=0.
  - halt_pend=0; wait_cnt=0.
  - Reset mid-instruction abandons the instruction; no retire pulse.
- States: IDLE, F, R, X, M, W, HALT. phase is one-hot in F..W and 0 in IDLE/HALT.
- halt_pend:
  - Set on any cycle with halt_req=1.
  - Cleared on the cycle HALT is entered.
- Transitions:
  - IDLE: halt_req|halt_pend -> HALT; else run=1 -> F; else stay. Halt wins over run when both are high.
  - F: imem_ack=1 -> R (ack on the first F cycle gives a 1-cycle F); else stay.
  - R -> X unconditionally.
  - X: mem_op=1 or SKIP_MEM=0 -> M; else -> W.
  - M: dmem_ack=1 -> W; else stay.
  - W: halt_pend or halt_req -> HALT; else -> F. The instruction in flight always completes; halt never aborts mid-instruction.
  - HALT: halted=1. run=1 and halt_req=0 -> F; else stay.
- Minimum instruction length: 4 cycles (F,R,X,W) with SKIP_MEM=1 and 0-wait ack; 5 cycles with M.
- wait_cnt, width $clog2(WAIT_TIMEOUT+1):
  - Cleared on entry to F or M.
  - Increments each cycle in F/M without ack; saturates.
  - If WAIT_TIMEOUT>0 and wait_cnt==WAIT_TIMEOUT with no ack: timeout_err<=1, -> HALT. Ack on that same cycle takes priority (normal transition).
  - timeout_err clears only on rst.
- Acks arriving outside F/M are ignored. mem_op is ignored outside X.
- Downstream PC update happens in the W cycle, so exactly one retire pulse per instruction.

Optional Feature:
- Macro: PHASE_SEQ_PERF_EN.
- When defined, adds outputs cycle_cnt[31:0] and instr_cnt[31:0]:
  - cycle_cnt increments every cycle state is not IDLE/HALT.
  - instr_cnt increments on retire.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - phase bit indices PH_F=0..PH_W=4 and phase width 5;
  - state encoding constants for the seven states.
- One natural sub-module: phase_wait_timer (wait_cnt, saturation, timeout compare), instantiated once and shared by F and M.
- Everything else stays in the sequencer FSM.

Test Plan:
- Reset then run=1, imem_ack tied 1, mem_op=0 -> phase sequence 00001,00010,00100,10000 repeating with period 4; retire every 4th cycle.
- mem_op=1 in X, dmem_ack asserted on 3rd M cycle -> phase 01000 held 3 cycles, then 10000; instruction length 7 cycles.
- halt_req 1-cycle pulse during R -> instruction completes through W; next cycle halted=1, phase=0. Then run=1 -> F next cycle.
- WAIT_TIMEOUT=4, imem_ack held 0 -> after 4 wait cycles timeout_err=1 and halted=1. Ack on the 4th cycle instead -> no error, advances to R.
- rst asserted asynchronously mid-M -> phase=0 and dmem_req=0 immediately without waiting for clk; no retire pulse.
- With PHASE_SEQ_PERF_EN: 10 instructions of 4 cycles -> instr_cnt=10, cycle_cnt=40.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the five-phase sequencer: phase bit indices, state
// encoding and the wait-counter width helper.
package phase_sequencer_pkg;

  localparam int PHASE_W = 5;
  localparam int PH_F    = 0;
  localparam int PH_R    = 1;
  localparam int PH_X    = 2;
  localparam int PH_M    = 3;
  localparam int PH_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_F    = 3'd1,
    ST_R    = 3'd2,
    ST_X    = 3'd3,
    ST_M    = 3'd4,
    ST_W    = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  // Keeps the counter at least one bit wide when the timeout is disabled.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/phase_wait_timer.sv
// Saturating wait counter shared by the F and M states; flags expiry when the
// count reaches WAIT_TIMEOUT (never when WAIT_TIMEOUT is 0).
module phase_wait_timer
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_wait,
  output logic o_expired
);

  localparam int CNT_W = cnt_width(WAIT_TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_wait && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (WAIT_TIMEOUT > 0) && (r_cnt == CNT_W'(WAIT_TIMEOUT));

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase (F,R,X,M,W) control sequencer with halt/run and memory-wait
// timeout. Define PHASE_SEQ_PERF_EN to add cycle/instruction counters.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255,
  parameter bit SKIP_MEM     = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_halt_req,
  input  logic               i_mem_op,
  input  logic               i_imem_ack,
  input  logic               i_dmem_ack,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_imem_req,
  output logic               o_dmem_req,
  output logic               o_retire,
  output logic               o_halted,
  output logic               o_timeout_err
`ifdef PHASE_SEQ_PERF_EN
  ,
  output logic [31:0]        o_cycle_cnt,
  output logic [31:0]        o_instr_cnt
`endif
);

  state_t r_state;
  state_t w_next;
  logic   r_halt_pend;
  logic   r_timeout_err;
  logic   w_timeout;
  logic   w_expired;
  logic   w_wait;
  logic   w_clr;

  assign w_wait = ((r_state == ST_F) && !i_imem_ack) ||
                  ((r_state == ST_M) && !i_dmem_ack);
  assign w_clr  = ((w_next == ST_F) || (w_next == ST_M)) && (w_next != r_state);

  phase_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_clr),
    .i_wait   (w_wait),
    .o_expired(w_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_halt_req || r_halt_pend) w_next = ST_HALT;
        else if (i_run)                w_next = ST_F;
      end
      ST_F: begin
        if (i_imem_ack) begin
          w_next = ST_R;
        end else if (w_expired) begin
          w_next    = ST_HALT;
          w_timeout = 1'b1;
        end
      end
      ST_R: w_next = ST_X;
      ST_X: w_next = (i_mem_op || !SKIP_MEM) ? ST_M : ST_W;
      ST_M: begin
        if (i_dmem_ack) begin
          w_next = ST_W;
        end else if (w_expired) begin
          w_next    = ST_HALT;
          w_timeout = 1'b1;
        end
      end
      ST_W:    w_next = (r_halt_pend || i_halt_req) ? ST_HALT : ST_F;
      ST_HALT: if (i_run && !i_halt_req) w_next = ST_F;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_halt_pend   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      // Entering HALT consumes the pending request, even one raised this cycle.
      if ((w_next == ST_HALT) && (r_state != ST_HALT)) r_halt_pend <= 1'b0;
      else if (i_halt_req)                             r_halt_pend <= 1'b1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    o_phase = '0;
    case (r_state)
      ST_F:    o_phase[PH_F] = 1'b1;
      ST_R:    o_phase[PH_R] = 1'b1;
      ST_X:    o_phase[PH_X] = 1'b1;
      ST_M:    o_phase[PH_M] = 1'b1;
      ST_W:    o_phase[PH_W] = 1'b1;
      default: o_phase = '0;
    endcase
  end

  assign o_imem_req    = (r_state == ST_F);
  assign o_dmem_req    = (r_state == ST_M);
  assign o_retire      = (r_state == ST_W);
  assign o_halted      = (r_state == ST_HALT);
  assign o_timeout_err = r_timeout_err;

`ifdef PHASE_SEQ_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if ((r_state != ST_IDLE) && (r_state != ST_HALT)) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_state == ST_W) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instr_cnt = r_instr_cnt;
`endif

endmodule
